// File: rtl/serial_operand_transmitter_msb_first.sv
// Serialises a parallel operand pair MSB first for a bit-serial comparator.
// Each frame is one comparator-clear cycle followed by WIDTH shift cycles.
module serial_operand_transmitter_msb_first #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             cmp_rst,
  output logic             out_valid,
  output logic             a_ser,
  output logic             b_ser,
  output logic             out_last,
  output logic             frame_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             fd_q, fd_d;
  logic             xfer;
  logic             last_bit;

  assign xfer     = in_valid & in_ready;
  assign last_bit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    fd_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = CLEAR;
          a_sh_d  = in_a;
          b_sh_d  = in_b;
        end
      end
      CLEAR: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        a_sh_d = {a_sh_q[WIDTH-2:0], 1'b0};
        b_sh_d = {b_sh_q[WIDTH-2:0], 1'b0};
        // counter holds at WIDTH-1 on the final bit, so it never wraps
        if (last_bit) begin
          state_d = IDLE;
          fd_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == IDLE) & ~rst;
    cmp_rst    = rst | (state_q == CLEAR);
    out_valid  = (state_q == SHIFT) & ~rst;
    a_ser      = out_valid & a_sh_q[WIDTH-1];
    b_ser      = out_valid & b_sh_q[WIDTH-1];
    out_last   = out_valid & last_bit;
    frame_done = fd_q;
  end

endmodule

// File: doc/serial_operand_transmitter_msb_first.md
SERIAL_OPERAND_TRANSMITTER_MSB_FIRST -- requirements
Module: serial_operand_transmitter_msb_first

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  parallel operand pair offered.
REQ-005 in_ready  output  1  block can accept an operand pair this cycle.
REQ-006 in_a  input  WIDTH  operand A, parallel.
REQ-007 in_b  input  WIDTH  operand B, parallel.
REQ-008 cmp_rst  output  1  clear pulse to the downstream serial comparator.
REQ-009 out_valid  output  1  a_ser/b_ser carry a valid bit this cycle.
REQ-010 a_ser  output  1  serial operand A bit, MSB first.
REQ-011 b_ser  output  1  serial operand B bit, MSB first.
REQ-012 out_last  output  1  current bit is the LSB of the frame.
REQ-013 frame_done  output  1  one-cycle pulse after a frame's final bit.

Function
REQ-014 FSM states: IDLE, CLEAR, SHIFT.
REQ-015 Handshake: transfer when in_valid & in_ready at posedge; in_a/in_b captured into shift registers a_sh/b_sh.
REQ-016 in_ready = (state == IDLE) & ~rst; combinational, no dependency on in_valid.
REQ-017 IDLE -> CLEAR on transfer; otherwise stays IDLE.
REQ-018 CLEAR lasts exactly 1 cycle; cmp_rst=1, out_valid=0; then -> SHIFT with bit counter = 0.
REQ-019 SHIFT lasts exactly WIDTH cycles; out_valid=1; a_ser=a_sh[WIDTH-1], b_ser=b_sh[WIDTH-1]; both registers shift left by 1 (zero fill) each cycle.
REQ-020 out_last=1 only in the SHIFT cycle with counter = WIDTH-1; 0 in all other cycles.
REQ-021 After the out_last cycle -> IDLE; frame_done=1 in that first IDLE cycle only.
REQ-022 Latency: transfer at edge T gives cmp_rst high in cycle T+1, MSB in cycle T+2, LSB in cycle T+WIDTH+1, frame_done in cycle T+WIDTH+2.
REQ-023 Back-to-back: a transfer accepted in the frame_done cycle is legal; its CLEAR cycle follows immediately, for minimum frame period WIDTH+2 cycles.
REQ-024 In IDLE and CLEAR: a_ser=0, b_ser=0, out_valid=0, out_last=0.
REQ-025 cmp_rst = rst | (state == CLEAR), so a downstream comparator clears on global reset and before every frame.
REQ-026 in_valid with in_ready=0 is ignored; the block latches no data and does not perturb the frame in progress.
REQ-027 Bit counter width is clog2(WIDTH); it shall not wrap inside a frame.

Reset
REQ-028 With rst=1 at posedge: state<=IDLE, counter<=0, a_sh<=0, b_sh<=0, frame_done<=0.
REQ-029 While rst=1: in_ready=0, out_valid=0, out_last=0, a_ser=0, b_ser=0, cmp_rst=1.
REQ-030 Reset mid-frame (CLEAR or SHIFT) abandons the frame; no frame_done pulse; first cycle after rst deasserts is IDLE with in_ready=1.

Verification (WIDTH=4 unless stated)
REQ-031 in_a=4'b1010, in_b=4'b1001 accepted at T -> cmp_rst=1 at T+1; a_ser 1,0,1,0 and b_ser 1,0,0,1 at T+2..T+5; out_last only at T+5; frame_done only at T+6.
REQ-032 Pair accepted at T and second pair (4'b0011, 4'b0100) held valid -> second accepted at T+6 (frame_done cycle); second cmp_rst at T+7; second MSBs a_ser=0, b_ser=0 at T+8.
REQ-033 in_valid held high and in_a toggling every cycle during SHIFT -> serial output matches the value captured at transfer; in_ready=0 throughout CLEAR/SHIFT.
REQ-034 rst asserted at the third SHIFT cycle -> cmp_rst=1 and out_valid=0 that cycle; no frame_done; IDLE with in_ready=1 on the first post-reset cycle.
REQ-035 Connect to the MSB-first serial comparator, WIDTH=8, pairs (8'h80,8'h7F), (8'h3C,8'h3C), (8'h01,8'h02) -> at out_last the comparator shows greater, equal, less.
REQ-036 WIDTH=2 build, in_a=2'b10, in_b=2'b01 -> 2 SHIFT cycles a_ser 1,0, b_ser 0,1; frame period 4 cycles under back-to-back load.
